bus_txn_history: RTL and testbench

//  Passive snooper for the Manta internal bus. Captures (addr, data, rw) of every valid bus beat into a

---
 rtl/bus_txn_pkg.sv | 28 ++
 rtl/bus_txn_history_ring.sv | 63 ++++++
 rtl/bus_txn_history.sv | 128 ++++++++++++
 tb/tb_bus_txn_history.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_txn_pkg.sv
// ============================================================================
// Module  : bus_txn_pkg
// Brief   : Shared beat type, default widths and capture-condition function
//           for the bus transaction history snooper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_txn_pkg;

  localparam int TXN_ADDR_W = 16;
  localparam int TXN_DATA_W = 16;

  typedef struct packed {
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_DATA_W-1:0] data;
    logic                  rw;
  } txn_t;

  localparam int TXN_W = $bits(txn_t);

  function automatic logic capture_en(input logic valid, input logic frz, input logic in_win);
    return valid & ~frz & in_win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_txn_history_ring.sv
// ============================================================================
// Module  : txn_ring
// Brief   : DEPTH-entry circular beat store with fill tracking and an
//           asynchronous read port addressed by age (0 = newest).
// Revision: 1.0
// ============================================================================
`default_nettype none

module txn_ring #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 33,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int FILL_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [IDX_W-1:0]  rd_age_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic [FILL_W-1:0] fill_o,
  output logic              full_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  rd_idx;

  assign full_o = (fill_q == FILL_W'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (!full_o) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is deliberately left uncleared by reset; fill gates its validity.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // DEPTH is a power of two, so index arithmetic wraps naturally.
  assign rd_idx    = wr_ptr_q - IDX_W'(1) - rd_age_i;
  assign rd_data_o = mem_q[rd_idx];
  assign fill_o    = fill_q;

endmodule

`default_nettype wire

// File: rtl/bus_txn_history.sv
// ============================================================================
// Module  : bus_txn_history
// Brief   : Passive bus snooper keeping a circular history of beats with a
//           steppable registered display. Optional address window filter
//           enabled by defining BUS_TXN_FILTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_txn_history
  import bus_txn_pkg::*;
#(
  parameter int ADDR_WIDTH  = TXN_ADDR_W,
  parameter int DATA_WIDTH  = TXN_DATA_W,
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bus_valid,
  input  logic [ADDR_WIDTH-1:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0]            bus_data,
  input  logic                             bus_rw,
  input  logic                             freeze,
  input  logic                             step,
`ifdef BUS_TXN_FILTER_EN
  input  logic [ADDR_WIDTH-1:0]            win_lo,
  input  logic [ADDR_WIDTH-1:0]            win_hi,
`endif
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] disp_val,
  output logic                             disp_rw,
  output logic [$clog2(DEPTH)-1:0]         disp_idx,
  output logic                             disp_valid,
  output logic [COUNT_WIDTH-1:0]           txn_count,
  output logic                             wrapped
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int FILL_W = IDX_W + 1;
  localparam int VAL_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int BEAT_W = VAL_W + 1;

  logic              in_win;
  logic              cap;
  logic [BEAT_W-1:0] rd_beat;
  logic [FILL_W-1:0] fill;
  logic              full;

  logic [IDX_W-1:0]       view_q, view_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wrapped_q, wrapped_d;
  logic [VAL_W-1:0]       disp_val_q, disp_val_d;
  logic                   disp_rw_q, disp_rw_d;
  logic [IDX_W-1:0]       disp_idx_q;
  logic                   disp_valid_q, disp_valid_d;

`ifdef BUS_TXN_FILTER_EN
  // An inverted window (lo > hi) can never be satisfied, so nothing is captured.
  assign in_win = (bus_addr >= win_lo) && (bus_addr <= win_hi);
`else
  assign in_win = 1'b1;
`endif

  assign cap = capture_en(bus_valid, freeze, in_win);

  txn_ring #(
    .DEPTH (DEPTH),
    .WIDTH (BEAT_W)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cap),
    .wr_data_i ({bus_addr, bus_data, bus_rw}),
    .rd_age_i  (view_q),
    .rd_data_o (rd_beat),
    .fill_o    (fill),
    .full_o    (full)
  );

  always_comb begin
    view_d       = view_q;
    count_d      = count_q;
    wrapped_d    = wrapped_q;
    disp_valid_d = (FILL_W'(view_q) < fill);
    disp_val_d   = disp_valid_d ? rd_beat[BEAT_W-1:1] : '0;
    disp_rw_d    = disp_valid_d ? rd_beat[0] : 1'b0;

    if (cap) begin
      view_d = '0;
      if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
      if (full) wrapped_d = 1'b1;
    end else if (step) begin
      // Wrap back to the newest entry once the oldest held one has been shown.
      if (fill == '0 || (FILL_W'(view_q) + FILL_W'(1)) == fill) view_d = '0;
      else view_d = view_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      view_q       <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      disp_val_q   <= '0;
      disp_rw_q    <= 1'b0;
      disp_idx_q   <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      view_q       <= view_d;
      count_q      <= count_d;
      wrapped_q    <= wrapped_d;
      disp_val_q   <= disp_val_d;
      disp_rw_q    <= disp_rw_d;
      disp_idx_q   <= view_q;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign disp_val   = disp_val_q;
  assign disp_rw    = disp_rw_q;
  assign disp_idx   = disp_idx_q;
  assign disp_valid = disp_valid_q;
  assign txn_count  = count_q;
  assign wrapped    = wrapped_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_txn_history.sv
// ============================================================================
// Module  : tb_bus_txn_history
// Brief   : Directed self-checking bench for bus_txn_history.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_txn_history;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_valid = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [15:0] bus_data = '0;
  logic        bus_rw = 1'b0;
  logic        freeze = 1'b0;
  logic        step = 1'b0;
`ifdef BUS_TXN_FILTER_EN
  logic [15:0] win_lo = '0;
  logic [15:0] win_hi = 16'hFFFF;
`endif
  logic [31:0] disp_val;
  logic        disp_rw;
  logic [2:0]  disp_idx;
  logic        disp_valid;
  logic [15:0] txn_count;
  logic        wrapped;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bus_txn_history #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (16),
    .DEPTH       (8),
    .COUNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_rw     (bus_rw),
    .freeze     (freeze),
    .step       (step),
`ifdef BUS_TXN_FILTER_EN
    .win_lo     (win_lo),
    .win_hi     (win_hi),
`endif
    .disp_val   (disp_val),
    .disp_rw    (disp_rw),
    .disp_idx   (disp_idx),
    .disp_valid (disp_valid),
    .txn_count  (txn_count),
    .wrapped    (wrapped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus_valid = 1'b0; step = 1'b0; freeze = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] d, input logic rw);
    bus_valid = 1'b1; bus_addr = a; bus_data = d; bus_rw = rw;
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  // Display tuple packed as {disp_val, disp_rw, disp_idx, disp_valid}.
  task automatic test_reset();
    logic [36:0] exp_disp;
    do_reset();
    repeat (10) tick();
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid, txn_count, wrapped} !== 54'd0)
      $display("FAIL reset_outputs: got val=%h rw=%b idx=%0d v=%b cnt=%h wr=%b, want all 0",
               disp_val, disp_rw, disp_idx, disp_valid, txn_count, wrapped);
    else passes++;
    pulse_step();
    exp_disp = 37'd0;
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid} !== exp_disp)
      $display("FAIL step_empty: got idx=%0d v=%b val=%h, want idx=0 v=0 val=0",
               disp_idx, disp_valid, disp_val);
    else passes++;
  endtask

  task automatic test_basic();
    drive_beat(16'h0010, 16'hBEEF, 1'b1);
    drive_beat(16'h0011, 16'h1234, 1'b0);
    tick();
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid} !== {32'h0011_1234, 1'b0, 3'd0, 1'b1})
      $display("FAIL basic_newest: got val=%h rw=%b idx=%0d v=%b, want 00111234 0 0 1",
               disp_val, disp_rw, disp_idx, disp_valid);
    else passes++;
    checks++;
    if (txn_count !== 16'd2) $display("FAIL basic_count: got %0d want 2", txn_count);
    else passes++;
    pulse_step();
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid} !== {32'h0010_BEEF, 1'b1, 3'd1, 1'b1})
      $display("FAIL basic_step1: got val=%h rw=%b idx=%0d v=%b, want 0010beef 1 1 1",
               disp_val, disp_rw, disp_idx, disp_valid);
    else passes++;
    pulse_step();
    checks++;
    if ({disp_val, disp_idx, disp_valid} !== {32'h0011_1234, 3'd0, 1'b1})
      $display("FAIL basic_step_wrap: got val=%h idx=%0d v=%b, want 00111234 0 1",
               disp_val, disp_idx, disp_valid);
    else passes++;
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus_valid = 1'b1; bus_addr = 16'(i); bus_data = 16'hA000 | 16'(i); bus_rw = i[0];
      tick();
    end
    bus_valid = 1'b0;
    tick();
    checks++;
    if ({wrapped, txn_count} !== {1'b1, 16'd9})
      $display("FAIL wrap_flag_count: got wr=%b cnt=%0d, want 1 9", wrapped, txn_count);
    else passes++;
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid} !== {32'h0008_A008, 1'b0, 3'd0, 1'b1})
      $display("FAIL wrap_newest: got val=%h rw=%b idx=%0d v=%b, want 0008a008 0 0 1",
               disp_val, disp_rw, disp_idx, disp_valid);
    else passes++;
    repeat (7) pulse_step();
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid} !== {32'h0001_A001, 1'b1, 3'd7, 1'b1})
      $display("FAIL wrap_oldest: got val=%h rw=%b idx=%0d v=%b, want 0001a001 1 7 1",
               disp_val, disp_rw, disp_idx, disp_valid);
    else passes++;
    pulse_step();
    checks++;
    if ({disp_val, disp_idx} !== {32'h0008_A008, 3'd0})
      $display("FAIL wrap_step_back: got val=%h idx=%0d, want 0008a008 0", disp_val, disp_idx);
    else passes++;
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    drive_beat(16'h0050, 16'h5050, 1'b1);
    drive_beat(16'h0051, 16'h5151, 1'b1);
    drive_beat(16'h0052, 16'h5252, 1'b0);
    tick();
    checks++;
    if (txn_count !== 16'd9) $display("FAIL freeze_count: got %0d want 9", txn_count);
    else passes++;
    checks++;
    if ({disp_val, disp_rw, disp_idx} !== {32'h0008_A008, 1'b0, 3'd0})
      $display("FAIL freeze_hold: got val=%h rw=%b idx=%0d, want 0008a008 0 0",
               disp_val, disp_rw, disp_idx);
    else passes++;
    pulse_step();
    checks++;
    if ({disp_val, disp_rw, disp_idx} !== {32'h0007_A007, 1'b1, 3'd1})
      $display("FAIL freeze_step: got val=%h rw=%b idx=%0d, want 0007a007 1 1",
               disp_val, disp_rw, disp_idx);
    else passes++;
    freeze = 1'b0;
    step = 1'b1;
    drive_beat(16'h0077, 16'h7777, 1'b1);
    step = 1'b0;
    tick();
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid} !== {32'h0077_7777, 1'b1, 3'd0, 1'b1})
      $display("FAIL step_vs_capture: got val=%h rw=%b idx=%0d v=%b, want 00777777 1 0 1",
               disp_val, disp_rw, disp_idx, disp_valid);
    else passes++;
    checks++;
    if (txn_count !== 16'd10) $display("FAIL unfreeze_count: got %0d want 10", txn_count);
    else passes++;
  endtask

  task automatic test_saturate_reset();
    do_reset();
    bus_valid = 1'b1; bus_rw = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus_addr = 16'(i); bus_data = ~16'(i);
      tick();
    end
    bus_valid = 1'b0;
    tick();
    checks++;
    if (txn_count !== 16'hFFFF) $display("FAIL count_saturate: got %h want ffff", txn_count);
    else passes++;
    checks++;
    if (wrapped !== 1'b1) $display("FAIL wrapped_sticky: got %b want 1", wrapped);
    else passes++;
    rst = 1'b1; bus_valid = 1'b1; step = 1'b1;
    tick();
    rst = 1'b0; bus_valid = 1'b0; step = 1'b0;
    checks++;
    if ({disp_val, disp_rw, disp_idx, disp_valid, txn_count, wrapped} !== 54'd0)
      $display("FAIL reset_priority: got val=%h rw=%b idx=%0d v=%b cnt=%h wr=%b, want all 0",
               disp_val, disp_rw, disp_idx, disp_valid, txn_count, wrapped);
    else passes++;
  endtask

`ifdef BUS_TXN_FILTER_EN
  task automatic test_filter();
    do_reset();
    win_lo = 16'h0100; win_hi = 16'h01FF;
    drive_beat(16'h00FF, 16'h1111, 1'b0);
    drive_beat(16'h0100, 16'h2222, 1'b0);
    drive_beat(16'h01FF, 16'h3333, 1'b1);
    drive_beat(16'h0200, 16'h4444, 1'b0);
    tick();
    checks++;
    if (txn_count !== 16'd2) $display("FAIL filter_count: got %0d want 2", txn_count);
    else passes++;
    checks++;
    if ({disp_val, disp_rw} !== {32'h01FF_3333, 1'b1})
      $display("FAIL filter_newest: got val=%h rw=%b, want 01ff3333 1", disp_val, disp_rw);
    else passes++;
    win_lo = 16'h0200; win_hi = 16'h0100;
    drive_beat(16'h0150, 16'h5555, 1'b0);
    tick();
    checks++;
    if (txn_count !== 16'd2) $display("FAIL filter_inverted: got %0d want 2", txn_count);
    else passes++;
    win_lo = 16'h0000; win_hi = 16'hFFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_wrap();
    test_freeze();
    test_saturate_reset();
`ifdef BUS_TXN_FILTER_EN
    test_filter();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
